wb_arbiter: RTL and testbench



---
 rtl/core_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 69 ++++++
 rtl/wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared writeback types: widths, the result entry carried from the functional
// units to the register file, and the source index order used for arbitration.
package core_pkg;

   localparam int PREG_W = 7;
   localparam int DATA_W = 32;
   localparam int ROB_W  = 4;

   localparam int N_SRC  = 3;
   localparam int N_PORT = 2;

   typedef struct packed {
      logic [PREG_W-1:0] rd;
      logic [DATA_W-1:0] data;
      logic [ROB_W-1:0]  rob;
   } wb_entry_t;

   // Enumeration order is the age/priority order among same-cycle results.
   typedef enum logic [1:0] {
      SRC_MEM  = 2'd0,
      SRC_ALU1 = 2'd1,
      SRC_ALU2 = 2'd2
   } src_idx_t;

endpackage

// File: rtl/wb_fifo.sv
// Overflow buffer for the writeback arbiter: circular buffer accepting up to
// three pushes and two pops per cycle. Head and head+1 are exposed so the
// arbiter can grant the two oldest buffered results ahead of new arrivals.
module wb_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic [1:0]       push_cnt,
   input  wb_entry_t        push_ent [N_SRC],
   input  logic [1:0]       pop_cnt,
   output wb_entry_t        head,
   output wb_entry_t        head_nxt,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // Pointers wrap modulo DEPTH so non-power-of-two depths also work.
   function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] ptr, input int inc);
      return PTR_W'((int'(ptr) + inc) % DEPTH);
   endfunction

   // Payload storage: pushes land at consecutive slots starting at wr_ptr.
   always_ff @(posedge clk) begin
      if (!flush) begin
         for (int k = 0; k < N_SRC; k++) begin
            if (k < int'(push_cnt)) begin
               mem[wrap(wr_ptr, k)] <= push_ent[k];
            end
         end
      end
   end

   // Pointer and occupancy update; pops and pushes can happen together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= wrap(rd_ptr, int'(pop_cnt));
         wr_ptr <= wrap(wr_ptr, int'(push_cnt));
         count  <= count - CNT_W'(pop_cnt) + CNT_W'(push_cnt);
      end
   end

   assign head     = mem[rd_ptr];
   assign head_nxt = mem[wrap(rd_ptr, 1)];

   a_no_underflow : assert property (@(posedge clk) disable iff (!reset_n)
      !flush |-> (int'(pop_cnt) <= int'(count)));

   a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
      !flush |-> ((int'(count) - int'(pop_cnt) + int'(push_cnt)) <= DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges results from MEM, ALU1 and ALU2 onto the two
// register-file write ports in age order. Buffered results are always older
// than new arrivals, so FIFO head entries are granted first; whatever does not
// fit on the two ports is pushed into the overflow FIFO. Outputs are registered.
module wb_arbiter
   import core_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int PREG_W = core_pkg::PREG_W,
   parameter int DATA_W = core_pkg::DATA_W,
   parameter int ROB_W  = core_pkg::ROB_W
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic [2:0]            src_valid,
   output logic                  src_ready,
   input  logic [3*PREG_W-1:0]   src_rd,
   input  logic [3*DATA_W-1:0]   src_data,
   input  logic [3*ROB_W-1:0]    src_rob,
   output logic [1:0]            wb_en,
   output logic [1:0]            wb_cmp,
   output logic [2*PREG_W-1:0]   wb_rd,
   output logic [2*DATA_W-1:0]   wb_data,
   output logic [2*ROB_W-1:0]    wb_rob
);

   // Entry layout comes from core_pkg; the width parameters exist for port
   // sizing and are expected to stay at their package defaults.
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int N_CAND = 2 + N_SRC;

   logic [CNT_W-1:0] fifo_count;
   wb_entry_t        fifo_head;
   wb_entry_t        fifo_head_nxt;

   wb_entry_t        src_ent  [N_SRC];
   logic [N_SRC-1:0] src_acc;

   wb_entry_t        cand     [N_CAND];
   logic [2:0]       n_cand;
   logic [1:0]       pop_cnt;
   logic [1:0]       push_cnt;
   wb_entry_t        push_ent [N_SRC];
   logic [N_PORT-1:0] grant;

   wb_entry_t        out_q    [N_PORT];

   // Ready depends only on registered occupancy: three free slots cover the
   // worst case of all sources arriving while nothing drains from the FIFO.
   assign src_ready = (int'(fifo_count) <= (DEPTH - 3));

   // Unpack the flat source buses and qualify each source with the handshake.
   always_comb begin
      for (int i = 0; i < N_SRC; i++) begin
         src_ent[i].rd   = src_rd[i*PREG_W +: PREG_W];
         src_ent[i].data = src_data[i*DATA_W +: DATA_W];
         src_ent[i].rob  = src_rob[i*ROB_W +: ROB_W];
      end
      src_acc = src_valid & {N_SRC{src_ready}};
   end

   // Build the age-ordered candidate list, grant the first two, push the rest.
   always_comb begin
      for (int c = 0; c < N_CAND; c++) begin
         cand[c] = '0;
      end
      n_cand  = 3'd0;
      pop_cnt = 2'd0;

      if (int'(fifo_count) >= 1) begin
         cand[0] = fifo_head;
         n_cand  = 3'd1;
         pop_cnt = 2'd1;
      end
      if (int'(fifo_count) >= 2) begin
         cand[1] = fifo_head_nxt;
         n_cand  = 3'd2;
         pop_cnt = 2'd2;
      end

      for (int i = int'(SRC_MEM); i <= int'(SRC_ALU2); i++) begin
         if (src_acc[i]) begin
            cand[n_cand] = src_ent[i];
            n_cand       = n_cand + 3'd1;
         end
      end

      grant[0] = (n_cand >= 3'd1);
      grant[1] = (n_cand >= 3'd2);
      push_cnt = (n_cand > 3'd2) ? 2'(n_cand - 3'd2) : 2'd0;
      for (int k = 0; k < N_SRC; k++) begin
         push_ent[k] = cand[k+2];
      end

      // A squash discards both the buffered results and this cycle's arrivals.
      if (flush) begin
         grant    = '0;
         pop_cnt  = 2'd0;
         push_cnt = 2'd0;
      end
   end

   wb_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .push_cnt (push_cnt),
      .push_ent (push_ent),
      .pop_cnt  (pop_cnt),
      .head     (fifo_head),
      .head_nxt (fifo_head_nxt),
      .count    (fifo_count)
   );

   // Register the granted entries; idle ports keep their last payload.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_cmp   <= '0;
         wb_en    <= '0;
         out_q[0] <= '0;
         out_q[1] <= '0;
      end else begin
         for (int p = 0; p < N_PORT; p++) begin
            wb_cmp[p] <= grant[p];
            wb_en[p]  <= grant[p] && (cand[p].rd != '0);
            if (grant[p]) begin
               out_q[p] <= cand[p];
            end
         end
      end
   end

   assign wb_rd   = {out_q[1].rd,   out_q[0].rd};
   assign wb_data = {out_q[1].data, out_q[0].data};
   assign wb_rob  = {out_q[1].rob,  out_q[0].rob};

   // Renaming hands out unique pregs, so both ports never write the same one.
   a_unique_preg : assert property (@(posedge clk) disable iff (!reset_n)
      ((wb_cmp == 2'b11) && (out_q[0].rd != '0)) |-> (out_q[0].rd != out_q[1].rd));

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand-written multi-cycle
// sequences and randomized traffic checked against a queue-based model.
module tb_wb_arbiter;
   import core_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic flush = 1'b0;
   logic [2:0] src_valid = '0;
   logic src_ready;
   logic [2:0][PREG_W-1:0] src_rd = '0;
   logic [2:0][DATA_W-1:0] src_data = '0;
   logic [2:0][ROB_W-1:0]  src_rob = '0;
   logic [1:0] wb_en;
   logic [1:0] wb_cmp;
   logic [1:0][PREG_W-1:0] wb_rd;
   logic [1:0][DATA_W-1:0] wb_data;
   logic [1:0][ROB_W-1:0]  wb_rob;

   wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_rd    (src_rd),
      .src_data  (src_data),
      .src_rob   (src_rob),
      .wb_en     (wb_en),
      .wb_cmp    (wb_cmp),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .wb_rob    (wb_rob)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   // ---------------- reference model: a plain age-ordered queue ----------------
   wb_entry_t   mq[$];
   wb_entry_t   m_out [2];
   logic [1:0]  m_cmp;
   logic [1:0]  m_en;
   int          log_rob[$];

   task automatic model_reset();
      mq.delete();
      m_out[0] = '0;
      m_out[1] = '0;
      m_cmp = '0;
      m_en = '0;
   endtask

   // Call right after a negedge with the inputs already driven.
   task automatic tick(output bit rdy);
      wb_entry_t e;
      rdy = (DEPTH - mq.size()) >= 3;
      chk("src_ready", src_ready, rdy);
      m_cmp = '0;
      m_en = '0;
      if (flush) begin
         mq.delete();
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (src_valid[i] && rdy) begin
               e.rd = src_rd[i];
               e.data = src_data[i];
               e.rob = src_rob[i];
               mq.push_back(e);
            end
         end
         for (int p = 0; p < 2; p++) begin
            if (mq.size() > 0) begin
               m_out[p] = mq.pop_front();
               m_cmp[p] = 1'b1;
               m_en[p] = (m_out[p].rd != '0);
               log_rob.push_back(int'(m_out[p].rob));
            end
         end
      end
      @(posedge clk);
      #1;
      chk("wb_cmp", wb_cmp, m_cmp);
      chk("wb_en", wb_en, m_en);
      for (int p = 0; p < 2; p++) begin
         chk("wb_rd", wb_rd[p], m_out[p].rd);
         chk("wb_data", wb_data[p], m_out[p].data);
         chk("wb_rob", wb_rob[p], m_out[p].rob);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      flush = 1'b0;
      src_valid = '0;
      model_reset();
      log_rob.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic drive_batch(input int base);
      flush = 1'b0;
      src_valid = 3'b111;
      for (int i = 0; i < 3; i++) begin
         src_rd[i] = PREG_W'(20 + base + i);
         src_data[i] = DATA_W'(32'h100 + base + i);
         src_rob[i] = ROB_W'(base + i);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic [2:0]             vld;
      logic                   fl;
      logic [2:0][PREG_W-1:0] rd;
      logic [2:0][DATA_W-1:0] dat;
      logic [2:0][ROB_W-1:0]  rob;
      logic                   rdy;
      logic [1:0]             cmp;
      logic [1:0]             en;
      logic [PREG_W-1:0]      rd0;
      logic [DATA_W-1:0]      d0;
      logic [ROB_W-1:0]       rob0;
      logic [PREG_W-1:0]      rd1;
      logic [DATA_W-1:0]      d1;
      logic [ROB_W-1:0]       rob1;
   } vec_t;

   vec_t tbl [8];

   initial begin
      bit rdy;
      int batch;
      int cyc;
      bit saw_low;

      tbl[0] = '{vld:3'b010, fl:1'b0, rd:{7'd0, 7'd5, 7'd0}, dat:{32'h0, 32'hAA, 32'h0}, rob:{4'd0, 4'd3, 4'd0},
                 rdy:1'b1, cmp:2'b01, en:2'b01, rd0:7'd5, d0:32'hAA, rob0:4'd3, rd1:7'd0, d1:32'h0, rob1:4'd0};
      tbl[1] = '{vld:3'b000, fl:1'b0, rd:'0, dat:'0, rob:'0,
                 rdy:1'b1, cmp:2'b00, en:2'b00, rd0:7'd0, d0:32'h0, rob0:4'd0, rd1:7'd0, d1:32'h0, rob1:4'd0};
      tbl[2] = '{vld:3'b111, fl:1'b0, rd:{7'd12, 7'd11, 7'd10}, dat:{32'h33, 32'h22, 32'h11}, rob:{4'd4, 4'd2, 4'd1},
                 rdy:1'b1, cmp:2'b11, en:2'b11, rd0:7'd10, d0:32'h11, rob0:4'd1, rd1:7'd11, d1:32'h22, rob1:4'd2};
      tbl[3] = '{vld:3'b000, fl:1'b0, rd:'0, dat:'0, rob:'0,
                 rdy:1'b1, cmp:2'b01, en:2'b01, rd0:7'd12, d0:32'h33, rob0:4'd4, rd1:7'd0, d1:32'h0, rob1:4'd0};
      tbl[4] = '{vld:3'b000, fl:1'b0, rd:'0, dat:'0, rob:'0,
                 rdy:1'b1, cmp:2'b00, en:2'b00, rd0:7'd0, d0:32'h0, rob0:4'd0, rd1:7'd0, d1:32'h0, rob1:4'd0};
      tbl[5] = '{vld:3'b001, fl:1'b0, rd:'0, dat:{32'h0, 32'h0, 32'h55}, rob:{4'd0, 4'd0, 4'd7},
                 rdy:1'b1, cmp:2'b01, en:2'b00, rd0:7'd0, d0:32'h55, rob0:4'd7, rd1:7'd0, d1:32'h0, rob1:4'd0};
      tbl[6] = '{vld:3'b100, fl:1'b1, rd:{7'd30, 7'd0, 7'd0}, dat:{32'h99, 32'h0, 32'h0}, rob:{4'd9, 4'd0, 4'd0},
                 rdy:1'b1, cmp:2'b00, en:2'b00, rd0:7'd0, d0:32'h0, rob0:4'd0, rd1:7'd0, d1:32'h0, rob1:4'd0};
      tbl[7] = '{vld:3'b000, fl:1'b0, rd:'0, dat:'0, rob:'0,
                 rdy:1'b1, cmp:2'b00, en:2'b00, rd0:7'd0, d0:32'h0, rob0:4'd0, rd1:7'd0, d1:32'h0, rob1:4'd0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_wb_en", wb_en, 2'b00);
      chk("rst_wb_cmp", wb_cmp, 2'b00);
      chk("rst_wb_rd", wb_rd, '0);
      chk("rst_wb_data", wb_data, '0);
      chk("rst_wb_rob", wb_rob, '0);
      chk("rst_src_ready", src_ready, 1'b1);
      reset_n = 1'b1;

      // Directed table
      for (int v = 0; v < 8; v++) begin
         @(negedge clk);
         src_valid = tbl[v].vld;
         flush = tbl[v].fl;
         src_rd = tbl[v].rd;
         src_data = tbl[v].dat;
         src_rob = tbl[v].rob;
         chk("tbl_ready", src_ready, tbl[v].rdy);
         @(posedge clk);
         #1;
         chk("tbl_cmp", wb_cmp, tbl[v].cmp);
         chk("tbl_en", wb_en, tbl[v].en);
         if (tbl[v].cmp[0]) begin
            chk("tbl_rd0", wb_rd[0], tbl[v].rd0);
            chk("tbl_data0", wb_data[0], tbl[v].d0);
            chk("tbl_rob0", wb_rob[0], tbl[v].rob0);
         end
         if (tbl[v].cmp[1]) begin
            chk("tbl_rd1", wb_rd[1], tbl[v].rd1);
            chk("tbl_data1", wb_data[1], tbl[v].d1);
            chk("tbl_rob1", wb_rob[1], tbl[v].rob1);
         end
      end

      // Three back-to-back three-source bursts; sources hold while not ready.
      do_reset();
      batch = 0;
      cyc = 0;
      saw_low = 1'b0;
      while (batch < 3 && cyc < 40) begin
         @(negedge clk);
         drive_batch(3 * batch);
         tick(rdy);
         if (!rdy) saw_low = 1'b1;
         else batch++;
         cyc++;
      end
      chk("burst_budget", batch, 3);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         src_valid = '0;
         tick(rdy);
      end
      chk("burst_ready_low", saw_low, 1'b1);
      chk("burst_count", log_rob.size(), 9);
      for (int k = 0; k < 9; k++) begin
         chk("burst_order", (k < log_rob.size()) ? log_rob[k] : 99, k);
      end

      // Flush with two buffered entries plus a new ALU2 result.
      do_reset();
      @(negedge clk); drive_batch(0); tick(rdy);
      @(negedge clk); drive_batch(3); tick(rdy);
      @(negedge clk);
      flush = 1'b1;
      src_valid = 3'b100;
      src_rd[2] = 7'd60;
      src_rob[2] = 4'd15;
      tick(rdy);
      chk("flush_cmp", wb_cmp, 2'b00);
      chk("flush_count", dut.u_fifo.count, 0);
      log_rob.delete();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         flush = 1'b0;
         src_valid = '0;
         tick(rdy);
      end
      // Flush while ready: input consumed and dropped.
      @(negedge clk);
      flush = 1'b1;
      src_valid = 3'b100;
      tick(rdy);
      @(negedge clk);
      flush = 1'b0;
      src_valid = '0;
      tick(rdy);
      chk("flush_dropped", log_rob.size(), 0);

      // Reset asserted mid-burst.
      do_reset();
      @(negedge clk); drive_batch(0); tick(rdy);
      @(negedge clk); drive_batch(3); tick(rdy);
      @(negedge clk);
      drive_batch(6);
      #2;
      reset_n = 1'b0;
      src_valid = '0;
      #1;
      chk("arst_wb_en", wb_en, 2'b00);
      chk("arst_wb_cmp", wb_cmp, 2'b00);
      chk("arst_ready", src_ready, 1'b1);
      chk("arst_wb_rd", wb_rd, '0);
      chk("arst_count", dut.u_fifo.count, 0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      src_valid = 3'b010;
      src_rd[1] = 7'd9;
      src_data[1] = 32'h77;
      src_rob[1] = 4'd5;
      tick(rdy);
      chk("arst_after_cmp", wb_cmp, 2'b01);
      chk("arst_after_rob", wb_rob[0], 4'd5);
      @(negedge clk);
      src_valid = '0;
      tick(rdy);

      // Randomized traffic with hold-until-transfer sources.
      begin
         logic [2:0] pend;
         wb_entry_t  pe [3];
         int         nxt_rd;
         do_reset();
         pend = '0;
         nxt_rd = 1;
         for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
               if (!pend[i] && ($urandom_range(0, 99) < 60)) begin
                  pend[i] = 1'b1;
                  if ($urandom_range(0, 7) == 0) begin
                     pe[i].rd = '0;
                  end else begin
                     pe[i].rd = PREG_W'(nxt_rd);
                     nxt_rd = (nxt_rd % 127) + 1;
                  end
                  pe[i].data = $urandom;
                  pe[i].rob = ROB_W'($urandom);
               end
               src_rd[i] = pend[i] ? pe[i].rd : PREG_W'($urandom);
               src_data[i] = pend[i] ? pe[i].data : $urandom;
               src_rob[i] = pend[i] ? pe[i].rob : ROB_W'($urandom);
            end
            src_valid = pend;
            flush = ($urandom_range(0, 49) == 0);
            tick(rdy);
            if (rdy) pend = '0;
         end
         @(negedge clk);
         src_valid = '0;
         flush = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
